// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: reads the synchronous fifo block and presents its words on a
// valid/ready stream. A 2-entry buffer hides the one-cycle read latency so a
// word can be delivered every cycle while the consumer keeps i_ready high.
//
// Handshake: a word transfers on a rising edge where o_valid && i_ready. Once
// o_valid is high, o_data stays stable and o_valid stays high until that edge.
module fifo_rd_stream #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_fifo_empty,
  output logic              o_fifo_rd_en,
  input  logic [DATA_W-1:0] i_fifo_rd_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
  output logic [CNT_W-1:0]  o_xfer_cnt
);

  logic [1:0]        occ;        // words held in the buffer, 0..2
  logic              infl;       // a pop was issued last edge; data on bus now
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] tail;
  logic [CNT_W-1:0]  xfer_cnt;
  logic              valid_q;

  logic              pop;
  logic [2:0]        level;      // occupancy after this edge, before new issue
  logic [1:0]        after_pop;  // occupancy once this cycle's pop leaves

  // Pop, next occupancy and the read strobe. The pop is counted so issuing
  // resumes in the very cycle the consumer frees a slot.
  always_comb begin
    pop          = valid_q && i_ready;
    level        = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
    after_pop    = occ - {1'b0, pop};
    o_fifo_rd_en = !rst && !i_fifo_empty && (level < 3'd2);
  end

  // Buffer, occupancy, in-flight flag and delivered-word counter. A read in
  // flight when rst asserts is dropped because infl is cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ      <= 2'd0;
      infl     <= 1'b0;
      head     <= '0;
      tail     <= '0;
      xfer_cnt <= '0;
      valid_q  <= 1'b0;
    end else begin
      infl    <= o_fifo_rd_en;
      occ     <= level[1:0];
      valid_q <= (level != 3'd0);
      // Full buffer draining one: the tail moves up to become the head.
      if (pop && (occ == 2'd2)) begin
        head <= tail;
      end
      // Capture the word returned by last cycle's read into the first free slot.
      if (infl) begin
        if (after_pop == 2'd0) begin
          head <= i_fifo_rd_data;
        end else begin
          tail <= i_fifo_rd_data;
        end
      end
      if (pop) begin
        xfer_cnt <= xfer_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign o_valid    = valid_q;
  assign o_data     = head;
  assign o_xfer_cnt = xfer_cnt;

  // Buffer plus in-flight read can never exceed the two storage slots.
  occ_bound_a : assert property (@(posedge clk) disable iff (rst)
    ({1'b0, occ} + {2'b00, infl}) <= 3'd2);

endmodule
